// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types and constants for the IM2 interrupt controller.
//   state_t       - controller state machine encoding
//   PAGE_*        - IO page (A[15:8]) decodes for mask, status and clear
//   DEF_VEC_BASE  - default IM2 vector base
//   vec_of()      - vector byte for a given source index
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [7:0] PAGE_MASK    = 8'h04;
  localparam logic [7:0] PAGE_STATUS  = 8'h05;
  localparam logic [7:0] PAGE_CLEAR   = 8'h06;
  localparam logic [7:0] DEF_VEC_BASE = 8'h80;

  // IM2 vectors are word-aligned table entries: base + 2*index.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
    return base + {4'b0000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: one interrupt line, 2-flop synchronizer plus rising-edge
// detector with a registered one-cycle pulse output.
//   clk        - system clock
//   nreset     - synchronous active-low reset
//   irq_in     - asynchronous request level
//   edge_pulse - one-cycle pulse, three edges after irq_in rises
module irq_sync_edge (
  input  logic clk,
  input  logic nreset,
  input  logic irq_in,
  output logic edge_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic hist_r;
  logic pulse_r;

  // Synchronizer chain, edge history and registered edge pulse.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
      pulse_r <= sync2_r & ~hist_r;
    end
  end

  assign edge_pulse = pulse_r;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: Z80-style IM2 maskable interrupt controller.
//   clk, nreset           - clock and synchronous active-low reset
//   irq[NSRC]             - asynchronous request levels, bit 0 highest priority
//   nM1, nIORQ, nRD, nWR  - CPU bus strobes (active-low)
//   A_hi                  - A[15:8], selects IO page (mask/status/clear)
//   D_in                  - CPU write data
//   D_out, D_oe           - combinational bus drive (vector or status)
//   nINT                  - registered interrupt request, low while asserting
//   ack[NSRC]             - one-cycle pulse on the acknowledged source
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         NSRC     = 4,
  parameter logic [7:0] VEC_BASE = DEF_VEC_BASE
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [NSRC-1:0] irq,
  input  logic            nM1,
  input  logic            nIORQ,
  input  logic            nRD,
  input  logic            nWR,
  input  logic [7:0]      A_hi,
  input  logic [7:0]      D_in,
  output logic [7:0]      D_out,
  output logic            D_oe,
  output logic            nINT,
  output logic [NSRC-1:0] ack
);

  state_t          state_r;
  state_t          state_n;
  logic [NSRC-1:0] edge_s;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] pending_n;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] active_s;
  logic [NSRC-1:0] win_onehot_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] ack_r;
  logic [2:0]      win_idx_s;
  logic            win_valid_s;
  logic [7:0]      vec_next_s;
  logic [7:0]      vector_r;
  logic            nint_r;
  logic            inta_s;
  logic            io_wr_s;
  logic            wr_seen_r;
  logic            wr_first_s;
  logic            ack_fire_s;
  logic            unused_din;

  // Only the low NSRC data bits carry mask/clear information.
  assign unused_din = ^D_in;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk        (clk),
      .nreset     (nreset),
      .irq_in     (irq[g]),
      .edge_pulse (edge_s[g])
    );
  end

  assign inta_s     = ~nM1 & ~nIORQ;
  assign io_wr_s    = ~nIORQ & ~nWR & nM1;
  // A write strobe lasts several cycles; act only on its first one.
  assign wr_first_s = io_wr_s & ~wr_seen_r;
  assign active_s   = pending_r & mask_r;

  // Lowest-index active source wins.
  always_comb begin
    win_idx_s   = 3'd0;
    win_valid_s = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active_s[i]) begin
        win_idx_s   = 3'(i);
        win_valid_s = 1'b1;
      end else begin
        win_idx_s   = win_idx_s;
        win_valid_s = win_valid_s;
      end
    end
  end

  assign win_onehot_s = NSRC'(1'b1) << win_idx_s;
  // An empty active set yields the spurious vector one slot past the last source.
  assign vec_next_s   = win_valid_s ? vec_of(VEC_BASE, win_idx_s) : vec_of(VEC_BASE, 3'(NSRC));
  assign ack_fire_s   = (state_r != ST_ACK) && inta_s && win_valid_s;

  // Pending update: acknowledge and W1C clears, with a same-cycle edge winning.
  always_comb begin
    clr_s = '0;
    if (ack_fire_s) begin
      clr_s = clr_s | win_onehot_s;
    end else begin
      clr_s = clr_s;
    end
    if (wr_first_s && (A_hi == PAGE_CLEAR)) begin
      clr_s = clr_s | D_in[NSRC-1:0];
    end else begin
      clr_s = clr_s;
    end
    pending_n = (pending_r & ~clr_s) | edge_s;
  end

  // Next-state logic for the IDLE/ASSERT/ACK controller.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (inta_s)           state_n = ST_ACK;
        else if (win_valid_s) state_n = ST_ASSERT;
        else                  state_n = ST_IDLE;
      end
      ST_ASSERT: begin
        if (inta_s)            state_n = ST_ACK;
        else if (!win_valid_s) state_n = ST_IDLE;
        else                   state_n = ST_ASSERT;
      end
      ST_ACK: begin
        if (!inta_s) state_n = ST_IDLE;
        else         state_n = ST_ACK;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Controller state, pending/mask registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      mask_r    <= '0;
      wr_seen_r <= 1'b0;
      nint_r    <= 1'b1;
      ack_r     <= '0;
      vector_r  <= VEC_BASE;
    end else begin
      state_r   <= state_n;
      pending_r <= pending_n;
      wr_seen_r <= io_wr_s;
      mask_r    <= (wr_first_s && (A_hi == PAGE_MASK)) ? D_in[NSRC-1:0] : mask_r;
      nint_r    <= (state_n != ST_ASSERT);
      ack_r     <= ack_fire_s ? win_onehot_s : '0;
      // The vector is captured on the ACK entry edge and held while in ACK.
      vector_r  <= (state_r != ST_ACK) ? vec_next_s : vector_r;
    end
  end

  // Bus drive: vector during INTA, else status read, else idle.
  always_comb begin
    D_oe  = 1'b0;
    D_out = 8'h00;
    if (inta_s) begin
      D_oe  = 1'b1;
      D_out = vector_r;
    end else if (~nIORQ && ~nRD && nM1 && (A_hi == PAGE_STATUS)) begin
      D_oe  = 1'b1;
      D_out = 8'(pending_r);
    end else begin
      D_oe  = 1'b0;
      D_out = 8'h00;
    end
  end

  assign nINT = nint_r;
  assign ack  = ack_r;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (NSRC=4, base 8'h80).
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] irq;
  logic       nM1, nIORQ, nRD, nWR;
  logic [7:0] A_hi, D_in, D_out;
  logic       D_oe, nINT;
  logic [3:0] ack;
  logic [7:0] rd;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(.NSRC(4), .VEC_BASE(8'h80)) dut (
    .clk(clk), .nreset(nreset), .irq(irq), .nM1(nM1), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .A_hi(A_hi), .D_in(D_in), .D_out(D_out),
    .D_oe(D_oe), .nINT(nINT), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic status_read(output logic [7:0] v);
    nIORQ = 1'b0; nRD = 1'b0; nM1 = 1'b1; A_hi = 8'h05;
    #1;
    v = D_out;
    nIORQ = 1'b1; nRD = 1'b1; A_hi = 8'h00;
    #1;
  endtask

  // IO write held for `hold` edges; only the first qualified edge may act.
  task automatic io_write(input logic [7:0] page, input logic [7:0] data, input int hold);
    nIORQ = 1'b0; nWR = 1'b0; nM1 = 1'b1; A_hi = page; D_in = data;
    ticks(hold);
    nIORQ = 1'b1; nWR = 1'b1; A_hi = 8'h00; D_in = 8'h00;
  endtask

  task automatic inta_on();
    nM1 = 1'b0; nIORQ = 1'b0;
  endtask

  task automatic inta_off();
    nM1 = 1'b1; nIORQ = 1'b1;
  endtask

  task automatic pulse_irq(input logic [3:0] bits);
    irq = irq | bits;
    tick();
    irq = irq & ~bits;
  endtask

  initial begin
    nreset = 1'b0; irq = 4'h0; nM1 = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    A_hi = 8'h00; D_in = 8'h00;
    ticks(2);
    check("rst_nint", 16'(nINT), 16'h1);
    check("rst_ack", 16'(ack), 16'h0);
    check("rst_doe", 16'(D_oe), 16'h0);
    check("rst_dout", 16'(D_out), 16'h00);
    nreset = 1'b1;
    tick();

    // Single source with full mask: latency, vector, ack and clear.
    io_write(8'h04, 8'h0F, 2);
    tick();
    irq[2] = 1'b1;
    tick();             // edge 0
    irq[2] = 1'b0;
    ticks(2);           // edges 1,2
    status_read(rd);
    check("lat_pend_e2", 16'(rd), 16'h00);
    tick();             // edge 3
    status_read(rd);
    check("lat_pend_e3", 16'(rd), 16'h04);
    check("lat_nint_e3", 16'(nINT), 16'h1);
    tick();             // edge 4
    check("lat_nint_e4", 16'(nINT), 16'h0);
    inta_on();
    tick();
    check("s2_vec", 16'(D_out), 16'h84);
    check("s2_doe", 16'(D_oe), 16'h1);
    check("s2_ack", 16'(ack), 16'h4);
    check("s2_nint", 16'(nINT), 16'h1);
    tick();
    check("s2_ack_1cyc", 16'(ack), 16'h0);
    inta_off();
    tick();
    status_read(rd);
    check("s2_pend_clr", 16'(rd), 16'h00);
    check("s2_nint_idle", 16'(nINT), 16'h1);

    // Two simultaneous sources: priority order of vectors.
    pulse_irq(4'b1010);
    ticks(4);
    check("pri_nint", 16'(nINT), 16'h0);
    inta_on();
    tick();
    check("pri_vec1", 16'(D_out), 16'h82);
    check("pri_ack1", 16'(ack), 16'h2);
    inta_off();
    ticks(2);
    check("pri_nint2", 16'(nINT), 16'h0);
    inta_on();
    tick();
    check("pri_vec2", 16'(D_out), 16'h86);
    check("pri_ack2", 16'(ack), 16'h8);
    inta_off();
    ticks(2);
    check("pri_nint_done", 16'(nINT), 16'h1);

    // Masked source stays pending; unmasking raises nINT next cycle.
    io_write(8'h04, 8'h00, 1);
    pulse_irq(4'b0001);
    ticks(5);
    check("msk_nint", 16'(nINT), 16'h1);
    status_read(rd);
    check("msk_status", 16'(rd), 16'h01);
    io_write(8'h04, 8'h01, 1);
    check("msk_nint_wr_edge", 16'(nINT), 16'h1);
    tick();
    check("msk_nint_unmask", 16'(nINT), 16'h0);
    inta_on();
    tick();
    check("msk_vec", 16'(D_out), 16'h80);
    check("msk_ack", 16'(ack), 16'h1);
    inta_off();
    tick();

    // W1C before INTA: request withdrawn, INTA becomes spurious.
    io_write(8'h04, 8'h0F, 1);
    pulse_irq(4'b0010);
    ticks(5);
    check("w1c_nint_pre", 16'(nINT), 16'h0);
    io_write(8'h06, 8'h02, 3);
    tick();
    check("w1c_nint", 16'(nINT), 16'h1);
    status_read(rd);
    check("w1c_status", 16'(rd), 16'h00);
    inta_on();
    tick();
    check("spur_vec", 16'(D_out), 16'h88);
    check("spur_ack", 16'(ack), 16'h0);
    tick();
    check("spur_ack2", 16'(ack), 16'h0);
    inta_off();
    tick();

    // New edge on the source being acknowledged: vector frozen, reasserts after.
    pulse_irq(4'b0001);
    ticks(4);
    inta_on();
    tick();
    check("reirq_ack", 16'(ack), 16'h1);
    pulse_irq(4'b0001);
    ticks(4);
    check("reirq_vec_frozen", 16'(D_out), 16'h80);
    check("reirq_nint_ack", 16'(nINT), 16'h1);
    inta_off();
    tick();
    tick();
    check("reirq_nint_again", 16'(nINT), 16'h0);
    inta_on();
    tick();
    check("reirq_ack2", 16'(ack), 16'h1);
    inta_off();
    tick();

    // Edge set coinciding with the acknowledge clear: set wins.
    pulse_irq(4'b0100);
    ticks(4);
    irq[2] = 1'b1;
    tick();             // e0
    irq[2] = 1'b0;
    ticks(2);           // e1, e2
    inta_on();
    tick();             // e3: ack clear and new set together
    check("coin_ack", 16'(ack), 16'h4);
    inta_off();
    ticks(2);
    check("coin_nint", 16'(nINT), 16'h0);
    status_read(rd);
    check("coin_status", 16'(rd), 16'h04);
    inta_on();
    tick();
    inta_off();
    tick();

    // Reset in the middle of ACK, with irq[3] held high through reset.
    pulse_irq(4'b0010);
    ticks(4);
    inta_on();
    tick();
    check("rack_ack", 16'(ack), 16'h2);
    irq[3] = 1'b1;
    nreset = 1'b0;
    tick();
    check("rack_nint", 16'(nINT), 16'h1);
    check("rack_ack0", 16'(ack), 16'h0);
    check("rack_vec", 16'(D_out), 16'h80);
    check("rack_doe", 16'(D_oe), 16'h1);
    inta_off();
    #1;
    check("rack_doe_off", 16'(D_oe), 16'h0);
    status_read(rd);
    check("rack_pend", 16'(rd), 16'h00);
    nreset = 1'b1;
    ticks(3);           // edges 0..2 after release
    status_read(rd);
    check("hold_e2", 16'(rd), 16'h00);
    tick();             // edge 3
    status_read(rd);
    check("hold_e3", 16'(rd), 16'h08);
    check("hold_nint", 16'(nINT), 16'h1);
    io_write(8'h06, 8'h08, 1);
    ticks(6);
    status_read(rd);
    check("hold_once", 16'(rd), 16'h00);
    io_write(8'h04, 8'h08, 1);
    tick();
    check("hold_nint_mask", 16'(nINT), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
